lenet_layer_sequencer: RTL

LENET_LAYER_SEQUENCER -- requirements
Module: lenet_layer_sequencer

---
 rtl/lenet_ctrl_pkg.sv | 26 ++
 rtl/lenet_argmax.sv | 46 ++++
 rtl/lenet_layer_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lenet_ctrl_pkg.sv
// Shared definitions for the LeNet layer sequencer: FSM states, layer ids
// and the score/class widths used by the sequencer and its argmax unit.
package lenet_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        ARGMAX,
        DONE,
        ERR
    } seq_state_t;

    localparam logic [2:0] CONV1 = 3'd0;
    localparam logic [2:0] POOL1 = 3'd1;
    localparam logic [2:0] CONV2 = 3'd2;
    localparam logic [2:0] POOL2 = 3'd3;
    localparam logic [2:0] FC1   = 3'd4;
    localparam logic [2:0] FC2   = 3'd5;
    localparam logic [2:0] FC3   = 3'd6;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 16;
    localparam int CLASS_W     = 4;

endpackage

// File: rtl/lenet_argmax.sv
// Running signed argmax over the final-layer score beats; the lower index wins ties.
module lenet_argmax
    import lenet_ctrl_pkg::*;
#(
    parameter int NUM_CLASSES = lenet_ctrl_pkg::NUM_CLASSES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               beat_valid,
    input  logic [SCORE_W-1:0] beat_data,
    output logic               last_beat,
    output logic [CLASS_W-1:0] result_index,
    output logic [SCORE_W-1:0] result_value
);

    logic [CLASS_W-1:0] count_reg;
    logic [CLASS_W-1:0] idx_reg;
    logic [SCORE_W-1:0] max_reg;
    logic               take;

    // Beat 0 always seeds the maximum; later beats must be strictly greater.
    assign take = beat_valid &&
                  ((count_reg == '0) || ($signed(beat_data) > $signed(max_reg)));

    assign result_value = take ? beat_data : max_reg;
    assign result_index = take ? count_reg : idx_reg;
    assign last_beat    = beat_valid && (count_reg == CLASS_W'(NUM_CLASSES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            idx_reg   <= '0;
            max_reg   <= '0;
        end else if (clear) begin
            count_reg <= '0;
            idx_reg   <= '0;
            max_reg   <= '0;
        end else if (beat_valid) begin
            count_reg <= count_reg + 1'b1;
            idx_reg   <= result_index;
            max_reg   <= result_value;
        end
    end

endmodule

// File: rtl/lenet_layer_sequencer.sv
// Launches the LeNet layers in order, then reduces the class scores to an
// argmax result; a per-phase watchdog parks the FSM in ERR on a stall.
module lenet_layer_sequencer
    import lenet_ctrl_pkg::*;
#(
    parameter int NUM_LAYERS     = 7,
    parameter int NUM_CLASSES    = lenet_ctrl_pkg::NUM_CLASSES,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        start,
    output logic        layer_start,
    output logic [2:0]  layer_id,
    input  logic        layer_done,
    input  logic        score_valid,
    input  logic [15:0] score_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  class_index,
    output logic [15:0] class_value
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0]         LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    seq_state_t         state_reg, state_next;
    logic               start_q;
    logic               start_edge;
    logic [2:0]         layer_id_reg, layer_id_next;
    logic [TIMER_W-1:0] timer_reg;
    logic               timed_state;
    logic               timer_expired;
    logic               accept_start;
    logic               argmax_clear;
    logic               beat_valid;
    logic               last_beat;
    logic [CLASS_W-1:0] result_index;
    logic [SCORE_W-1:0] result_value;
    logic [CLASS_W-1:0] class_index_reg;
    logic [SCORE_W-1:0] class_value_reg;

    assign start_edge    = start & ~start_q;
    assign timed_state   = (state_reg == WAIT) || (state_reg == ARGMAX);
    assign timer_expired = timed_state && (timer_reg == TIMER_LAST);
    assign beat_valid    = score_valid && (state_reg == ARGMAX);

    always_comb begin
        state_next    = state_reg;
        layer_id_next = layer_id_reg;
        accept_start  = 1'b0;
        argmax_clear  = 1'b0;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start_edge) begin
                    state_next    = LAUNCH;
                    layer_id_next = CONV1;
                    accept_start  = 1'b1;
                end
            end
            LAUNCH: state_next = WAIT;
            WAIT: begin
                // A completion arriving with the watchdog expiry still counts.
                if (layer_done) begin
                    if (layer_id_reg == LAST_LAYER) begin
                        state_next   = ARGMAX;
                        argmax_clear = 1'b1;
                    end else begin
                        state_next    = LAUNCH;
                        layer_id_next = layer_id_reg + 3'd1;
                    end
                end else if (timer_expired) begin
                    state_next = ERR;
                end
            end
            ARGMAX: begin
                if (last_beat) begin
                    state_next = DONE;
                end else if (timer_expired) begin
                    state_next = ERR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            start_q         <= 1'b0;
            layer_id_reg    <= '0;
            timer_reg       <= '0;
            class_index_reg <= '0;
            class_value_reg <= '0;
        end else begin
            state_reg    <= state_next;
            start_q      <= start;
            layer_id_reg <= layer_id_next;
            // Restart the watchdog on every phase change so each WAIT/ARGMAX gets a full budget.
            if (timed_state && (state_next == state_reg)) begin
                timer_reg <= timer_reg + 1'b1;
            end else begin
                timer_reg <= '0;
            end
            if (accept_start) begin
                class_index_reg <= '0;
                class_value_reg <= '0;
            end else if (last_beat) begin
                class_index_reg <= result_index;
                class_value_reg <= result_value;
            end
        end
    end

    lenet_argmax #(
        .NUM_CLASSES (NUM_CLASSES)
    ) u_argmax (
        .clk          (sys_clk),
        .rst          (rst),
        .clear        (argmax_clear),
        .beat_valid   (beat_valid),
        .beat_data    (score_data),
        .last_beat    (last_beat),
        .result_index (result_index),
        .result_value (result_value)
    );

    assign layer_start = (state_reg == LAUNCH);
    assign busy        = (state_reg == LAUNCH) || timed_state;
    assign done        = (state_reg == DONE);
    assign error       = (state_reg == ERR);
    assign layer_id    = layer_id_reg;
    assign class_index = class_index_reg;
    assign class_value = class_value_reg;

endmodule
